// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one-entry holding buffer per functional unit,
// one registered broadcast per cycle, squash flushes every pending result.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned XLEN    = 32,
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic [NUM_REQ*XLEN-1:0]  req_value,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     squash_valid,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_value,
    output logic [SRC_W-1:0]         cdb_src
);

    logic [NUM_REQ-1:0] buf_valid;
    logic [TAG_W-1:0]   buf_tag   [NUM_REQ];
    logic [XLEN-1:0]    buf_value [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   scan_idx;
    logic [SRC_W-1:0]   next_ptr;

    // First occupied buffer at or after rr_ptr, wrapping around the unit count.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_grant && buf_valid[scan_idx]) begin
                any_grant        = 1'b1;
                grant[scan_idx]  = 1'b1;
                winner           = scan_idx;
            end
        end
    end

    assign next_ptr  = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign req_ready = squash_valid ? '0 : (~buf_valid | grant);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_tag[i]   <= '0;
                buf_value[i] <= '0;
            end
        end else if (squash_valid) begin
            buf_valid <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else begin
            if (any_grant) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= buf_tag[winner];
                cdb_value <= buf_value[winner];
                cdb_src   <= winner;
                rr_ptr    <= next_ptr;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_value <= '0;
                cdb_src   <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
                // Tag 0 completes the handshake but is dropped; a same-cycle refill wins over the clear.
                if (req_valid[i] && req_ready[i] && (req_tag[i*TAG_W +: TAG_W] != '0)) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                    buf_value[i] <= req_value[i*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-cycle comparison against a queue-level model plus
// directed vectors with hand-computed expectations.
module tb_cdb_arbiter;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [3:0]    t_tag [N];
    logic [31:0]   t_val [N];
    logic [4*N-1:0]  req_tag;
    logic [32*N-1:0] req_value;
    logic [N-1:0]  req_ready;
    logic          squash_valid = 1'b0;
    logic          cdb_valid;
    logic [3:0]    cdb_tag;
    logic [31:0]   cdb_value;
    logic [1:0]    cdb_src;

    assign req_tag   = {t_tag[3], t_tag[2], t_tag[1], t_tag[0]};
    assign req_value = {t_val[3], t_val[2], t_val[1], t_val[0]};

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(4), .XLEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .squash_valid(squash_valid),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy/contents per unit, rotating priority pointer, expected broadcast.
    bit          m_full [N];
    logic [3:0]  m_tag  [N];
    logic [31:0] m_val  [N];
    int          m_ptr;
    logic        e_valid;
    logic [3:0]  e_tag;
    logic [31:0] e_val;
    int          e_src;
    int          m_win;
    bit          m_rdy [N];

    function automatic int model_winner();
        for (int k = 0; k < N; k++)
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ptr = 0; e_valid = 0; e_tag = 0; e_val = 0; e_src = 0;
        end else begin
            m_win = model_winner();
            for (int i = 0; i < N; i++) m_rdy[i] = !squash_valid && (!m_full[i] || i == m_win);
            if (squash_valid) begin
                for (int i = 0; i < N; i++) m_full[i] = 1'b0;
                e_valid = 0; e_tag = 0; e_val = 0; e_src = 0;
            end else begin
                if (m_win >= 0) begin
                    e_valid = 1; e_tag = m_tag[m_win]; e_val = m_val[m_win]; e_src = m_win;
                    m_full[m_win] = 1'b0;
                    m_ptr = (m_win + 1) % N;
                end else begin
                    e_valid = 0; e_tag = 0; e_val = 0; e_src = 0;
                end
                for (int i = 0; i < N; i++)
                    if (req_valid[i] && m_rdy[i] && t_tag[i] != 4'd0) begin
                        m_full[i] = 1'b1; m_tag[i] = t_tag[i]; m_val[i] = t_val[i];
                    end
            end
        end
    end

    always @(negedge clock) begin
        logic [N-1:0] exp_rdy;
        int w;
        w = model_winner();
        for (int i = 0; i < N; i++) exp_rdy[i] = !squash_valid && (!m_full[i] || i == w);
        if (reset) exp_rdy = squash_valid ? '0 : '1;
        check("model_cdb_valid", 64'(cdb_valid), 64'(e_valid));
        check("model_cdb_tag",   64'(cdb_tag),   64'(e_tag));
        check("model_cdb_value", 64'(cdb_value), 64'(e_val));
        check("model_cdb_src",   64'(cdb_src),   64'(e_src));
        check("model_req_ready", 64'(req_ready), 64'(exp_rdy));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [N-1:0] hs;
        int nt;
        for (int i = 0; i < N; i++) begin t_tag[i] = 4'd0; t_val[i] = 32'd0; end
        #1 reset = 1'b1;

        // Reset then idle
        repeat (2) @(posedge clock);
        #1;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_tag",   64'(cdb_tag),   64'd0);
        check("rst_cdb_value", 64'(cdb_value), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(req_ready), 64'hF);
        repeat (10) step();
        check("idle_cdb_valid", 64'(cdb_valid), 64'd0);

        // All four units stream tags 1..12: broadcast order 1..12 from units 0,1,2,3,0,...
        nt = 1;
        for (int i = 0; i < N; i++) begin
            t_tag[i] = 4'(nt); t_val[i] = 32'hA000_0000 | 32'(nt); nt++;
        end
        req_valid = 4'hF;
        for (int e = 1; e <= 13; e++) begin
            hs = req_valid & req_ready;
            step();
            if (e >= 2) begin
                check("stream_valid", 64'(cdb_valid), 64'd1);
                check("stream_tag",   64'(cdb_tag),   64'(e - 1));
                check("stream_src",   64'(cdb_src),   64'((e - 2) % 4));
            end
            for (int i = 0; i < N; i++)
                if (hs[i]) begin
                    if (nt <= 12) begin
                        t_tag[i] = 4'(nt); t_val[i] = 32'hA000_0000 | 32'(nt); nt++;
                    end else req_valid[i] = 1'b0;
                end
        end
        req_valid = '0;
        step();
        check("stream_drained", 64'(cdb_valid), 64'd0);

        // Reset mid-broadcast, then priority restarts at unit 0
        req_valid = 4'b0010; t_tag[1] = 4'd7; t_val[1] = 32'h1234_5678;
        step();
        req_valid = '0;
        step();
        check("pre_rst_valid", 64'(cdb_valid), 64'd1);
        check("pre_rst_tag",   64'(cdb_tag),   64'd7);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(cdb_valid), 64'd0);
        check("async_rst_tag",   64'(cdb_tag),   64'd0);
        check("async_rst_value", 64'(cdb_value), 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'hF);
        req_valid = 4'b1001;
        t_tag[0] = 4'd9;  t_val[0] = 32'h0000_0009;
        t_tag[3] = 4'd10; t_val[3] = 32'h0000_000A;
        step();
        req_valid = '0;
        step();
        check("restart_src0", 64'(cdb_src), 64'd0);
        check("restart_tag9", 64'(cdb_tag), 64'd9);
        step();
        check("restart_src3", 64'(cdb_src), 64'd3);
        step();
        check("restart_idle", 64'(cdb_valid), 64'd0);

        // Single request from unit 2: broadcast two edges later, for one cycle only
        req_valid = 4'b0100; t_tag[2] = 4'd5; t_val[2] = 32'hDEAD_BEEF;
        step();
        req_valid = '0;
        check("single_k1_valid", 64'(cdb_valid), 64'd0);
        step();
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_tag",   64'(cdb_tag),   64'd5);
        check("single_value", 64'(cdb_value), 64'hDEAD_BEEF);
        check("single_src",   64'(cdb_src),   64'd2);
        step();
        check("single_once", 64'(cdb_valid), 64'd0);

        // Tag 0 is consumed but never broadcast
        req_valid = 4'b0010; t_tag[1] = 4'd0; t_val[1] = 32'h5555_5555;
        #1;
        check("tag0_ready", 64'(req_ready[1]), 64'd1);
        step();
        req_valid = '0;
        check("tag0_still_ready", 64'(req_ready[1]), 64'd1);
        repeat (3) begin
            step();
            check("tag0_no_bcast", 64'(cdb_valid), 64'd0);
        end

        // Squash with buffers 0,1,3 full (pointer at 3, so unit 3 would win this edge)
        req_valid = 4'b1011;
        t_tag[0] = 4'd1; t_tag[1] = 4'd2; t_tag[3] = 4'd3;
        step();
        squash_valid = 1'b1;
        t_tag[0] = 4'd4; t_tag[1] = 4'd5; t_tag[3] = 4'd6;
        #1;
        check("squash_ready", 64'(req_ready), 64'h0);
        step();
        squash_valid = 1'b0;
        req_valid = '0;
        check("squash_no_bcast", 64'(cdb_valid), 64'd0);
        repeat (3) begin
            step();
            check("squash_empty", 64'(cdb_valid), 64'd0);
            check("squash_ready_all", 64'(req_ready), 64'hF);
        end
        req_valid = 4'b1001;
        t_tag[0] = 4'd11; t_tag[3] = 4'd12;
        step();
        req_valid = '0;
        step();
        check("post_squash_src3", 64'(cdb_src), 64'd3);
        check("post_squash_tag",  64'(cdb_tag), 64'd12);
        step();
        check("post_squash_src0", 64'(cdb_src), 64'd0);
        step();
        check("post_squash_idle", 64'(cdb_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional units completing instructions. Each unit hands its result (ROB tag plus value) to a one-entry holding buffer. The arbiter picks one occupied buffer per cycle and drives a registered CDB packet that the ROB and reservation stations consume. Squash flushes all pending results so nothing stale is broadcast after a misprediction.

## Interface
- NUM_REQ, 4, number of requesting functional units (2..8)
- TAG_W, 4, ROB tag width; tag 0 means "no instruction"
- XLEN, 32, result value width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-unit result valid
- req_tag  in  NUM_REQ×TAG_W  per-unit ROB tag of the completing instruction
- req_value  in  NUM_REQ×XLEN  per-unit result value
- req_ready  out  NUM_REQ  per-unit: holding buffer can accept this cycle
- squash_valid  in  1  misprediction flush from the branch unit
- cdb_valid  out  1  broadcast valid this cycle
- cdb_tag  out  TAG_W  broadcast ROB tag (0 when cdb_valid=0)
- cdb_value  out  XLEN  broadcast value (0 when cdb_valid=0)
- cdb_src  out  clog2(NUM_REQ)  index of the unit being broadcast (debug/verification)

## Operation
- State per unit i: buf_valid[i], buf_tag[i], buf_value[i]. Global state: rr_ptr (clog2(NUM_REQ) bits).
- Registered outputs: cdb_valid, cdb_tag, cdb_value, cdb_src.
- Accept: req_valid[i] && req_ready[i] at an edge loads the buffer, with one exception. A request with req_tag==0 is consumed (handshake completes) but not buffered.
- Arbitration (combinational on buffer state):
  - Scan units rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - The first unit with buf_valid set gets grant[i]=1. At most one grant per cycle.
- req_ready[i] = !squash_valid && (!buf_valid[i] || grant[i]). A granted buffer can be refilled in the same cycle.
- On a grant at the edge:
  - cdb_* load the winner's buffer contents.
  - buf_valid[winner] clears, unless it is simultaneously refilled.
  - rr_ptr becomes (winner+1) mod NUM_REQ.
- No grant: cdb_valid, cdb_tag, cdb_value and cdb_src load 0, and rr_ptr holds.
- Fairness: a continuously occupied buffer is granted within NUM_REQ cycles.
- Squash: squash_valid high at an edge
  - clears every buf_valid;
  - zeroes the cdb_* registers;
  - keeps rr_ptr unchanged;
  - forces req_ready low that cycle, so no result is accepted.
  - Squash has priority over accept and grant in the same cycle.
- Reset (asynchronous, any time, including mid-broadcast): all buffers invalid, rr_ptr=0, and all outputs 0. req_ready reads 1 for every unit once reset deasserts.
- Buffer contents are don't-care while buf_valid=0. The implementation zeroes them on reset only.

## Timing
- Latency: a result accepted at edge k is in its buffer during cycle k+1. If it wins arbitration in cycle k+1, it appears on cdb_* during cycle k+2, i.e. 2 cycles at minimum.
- Throughput: one broadcast per cycle total. Each unit can sustain one result per cycle only while it wins every cycle (sole requester).
- req_ready is combinational from buffer state and squash_valid. Producers must not make req_valid depend on req_ready.
- cdb_* are stable for the full cycle after each edge; consumers sample them at the next edge.
- Boundary conditions:
  - All buffers full and all req_valid high: exactly one unit has req_ready=1 (the granted one).
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Squash on the same edge as a grant: the grant is discarded and cdb_valid=0 next cycle.
  - Squash while cdb_valid=1: the broadcast already visible this cycle still completes. Suppressing it in consumers is their responsibility; this block only guarantees nothing new after the edge.

## Test plan
- Reset then idle:
  - During reset: cdb_valid=0, cdb_tag=0, cdb_value=0.
  - After reset deasserts: req_ready=4'b1111.
  - With no requests, outputs stay 0 for 10 cycles.
- Single request: unit 2 presents tag 5, value 32'hDEAD_BEEF at edge k. Required: cdb_valid=1, tag=5, value=DEAD_BEEF, cdb_src=2 in cycle k+2 only.
- All four units request simultaneously and keep requesting with fresh tags 1..12. Required:
  - cdb_src sequence 0,1,2,3,0,1,…
  - no unit waits more than 4 cycles;
  - one broadcast every cycle.
- Tag 0: unit 1 requests with tag 0. Required: the handshake completes, and no broadcast follows (cdb_valid stays 0).
- Squash with buffers 0, 1, 3 full:
  - On the squash edge, req_ready=0 for all units.
  - Next cycle: cdb_valid=0 and all buffers empty, with no broadcast of the old tags ever.
  - rr_ptr unchanged: the next request from unit 3 alone is granted normally.
- Reset asserted mid-stream while cdb_valid=1: outputs go to 0 immediately (asynchronous). After release, arbitration restarts with unit 0 highest priority.
